// File: rtl/echo_delay_ctrl_pkg.sv
// ============================================================================
// Module  : echo_pkg
// Purpose : Shared types and constants for the echo delay-line sequencer:
//           FSM state encoding, alpha (Q1.15 gain) type, default ramp step
//           and the alpha ramp helper used by the optional ramp build.
// Ports   : none (package)
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package echo_pkg;

    typedef enum logic [0:0] {
        FILL = 1'b0,
        RUN  = 1'b1
    } echo_state_t;

    localparam int ALPHA_W = 16;

    typedef logic signed [ALPHA_W-1:0] alpha_t;

    localparam alpha_t ALPHA_STEP_DEFAULT = 16'sd64;

    // Move cur one step toward req, snapping when within one step.
    // The difference is taken in ALPHA_W+1 bits so full-scale swings
    // (e.g. -32768 -> 32767) cannot overflow.
    function automatic alpha_t alpha_ramp(input alpha_t cur,
                                          input alpha_t req,
                                          input alpha_t step);
        logic signed [ALPHA_W:0] diff;
        logic signed [ALPHA_W:0] step_x;
        alpha_t                  res;
        diff   = {req[ALPHA_W-1], req} - {cur[ALPHA_W-1], cur};
        step_x = {step[ALPHA_W-1], step};
        if (diff > step_x) begin
            res = cur + step;
        end else if (diff < -step_x) begin
            res = cur - step;
        end else begin
            res = req;
        end
        return res;
    endfunction

endpackage

`default_nettype wire

// File: rtl/echo_delay_ctrl_valid_pipe.sv
// ============================================================================
// Module  : echo_valid_pipe
// Purpose : DEPTH-stage shift register carrying {echo_valid, echo_en} so the
//           flags line up with BRAM read data. Fully cleared by rst so no
//           in-flight pulse survives a reset.
// Ports   : clk, rst        - clock, synchronous active-high reset
//           in_valid, in_en - flags issued with the sample (ram_we cycle)
//           out_valid,out_en- flags delayed by DEPTH cycles
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module echo_valid_pipe
    import echo_pkg::*;
#(
    parameter int DEPTH = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic in_valid,
    input  logic in_en,
    output logic out_valid,
    output logic out_en
);

    logic [DEPTH-1:0] valid_q;
    logic [DEPTH-1:0] valid_d;
    logic [DEPTH-1:0] en_q;
    logic [DEPTH-1:0] en_d;

    always_comb begin
        valid_d    = valid_q;
        en_d       = en_q;
        valid_d[0] = in_valid;
        en_d[0]    = in_en;
        for (int i = 1; i < DEPTH; i++) begin
            valid_d[i] = valid_q[i-1];
            en_d[i]    = en_q[i-1];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
            en_q    <= '0;
        end else begin
            valid_q <= valid_d;
            en_q    <= en_d;
        end
    end

    assign out_valid = valid_q[DEPTH-1];
    assign out_en    = en_q[DEPTH-1];

endmodule

`default_nettype wire

// File: rtl/echo_delay_ctrl.sv
// ============================================================================
// Module  : echo_delay_ctrl
// Purpose : Echo delay-line sequencer. Owns BRAM write/read pointers, the
//           per-sample write strobe, the echo-enable gate and the alpha
//           (echo gain) register. A delay change mutes the echo and refills
//           the delay line before history is used again.
// Config  : `define ECHO_ALPHA_RAMP_EN to ramp alpha_out toward alpha_req by
//           ALPHA_STEP per sample; otherwise alpha_req loads directly.
// Ports   : clk, rst     - clock, synchronous active-high reset
//           sample_valid - one-cycle strobe per input sample
//           delay_req    - requested delay (samples); delay_load latches it
//           alpha_req    - requested gain, signed Q1.15
//           ram_we/ram_waddr/ram_raddr - BRAM control, one write per sample
//           echo_valid   - BRAM read data valid (ram_we delayed RD_LAT)
//           echo_en      - read data is real history (else mute echo)
//           alpha_out    - gain to multiplier, changes only on issue
//           delay_cur    - delay in effect; busy - high while refilling
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module echo_delay_ctrl
    import echo_pkg::*;
#(
    parameter int     ADDR_W     = 20,
    parameter int     RD_LAT     = 1,
    parameter alpha_t ALPHA_STEP = ALPHA_STEP_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sample_valid,
    input  logic [ADDR_W-1:0] delay_req,
    input  logic              delay_load,
    input  alpha_t            alpha_req,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_waddr,
    output logic [ADDR_W-1:0] ram_raddr,
    output logic              echo_valid,
    output logic              echo_en,
    output alpha_t            alpha_out,
    output logic [ADDR_W-1:0] delay_cur,
    output logic              busy
);

    // Parameter sanity: BRAM latency range and a positive ramp step.
    generate
        if (RD_LAT < 1 || RD_LAT > 4 || ALPHA_STEP <= 0) begin : g_bad_param
            $error("echo_delay_ctrl: RD_LAT must be 1..4 and ALPHA_STEP > 0");
        end
    endgenerate

    echo_state_t       state_q,     state_d;
    logic [ADDR_W-1:0] wptr_q,      wptr_d;
    logic [ADDR_W-1:0] fill_cnt_q,  fill_cnt_d;
    logic [ADDR_W-1:0] delay_cur_q, delay_cur_d;
    logic [ADDR_W-1:0] ram_waddr_q, ram_waddr_d;
    logic [ADDR_W-1:0] ram_raddr_q, ram_raddr_d;
    logic              ram_we_q,    ram_we_d;
    logic              issue_en_q,  issue_en_d;
    logic              busy_q,      busy_d;
    alpha_t            alpha_q,     alpha_d;

    // One extra bit so fill_cnt+1 never wraps when delay_cur is all-ones.
    logic [ADDR_W:0]   fill_next;

    always_comb begin
        state_d     = state_q;
        wptr_d      = wptr_q;
        fill_cnt_d  = fill_cnt_q;
        delay_cur_d = delay_cur_q;
        ram_waddr_d = ram_waddr_q;
        ram_raddr_d = ram_raddr_q;
        alpha_d     = alpha_q;
        fill_next   = {1'b0, fill_cnt_q} + {{ADDR_W{1'b0}}, 1'b1};

        // Issue uses the delay and state as they stand this cycle, so a
        // coincident delay_load only affects the following sample.
        ram_we_d   = sample_valid;
        issue_en_d = sample_valid && (state_q == RUN);

        if (sample_valid) begin
            ram_waddr_d = wptr_q;
            ram_raddr_d = wptr_q - delay_cur_q;
            wptr_d      = wptr_q + {{(ADDR_W-1){1'b0}}, 1'b1};
`ifdef ECHO_ALPHA_RAMP_EN
            alpha_d     = alpha_ramp(alpha_q, alpha_req, ALPHA_STEP);
`else
            alpha_d     = alpha_req;
`endif
            if (state_q == FILL) begin
                if (fill_cnt_q < delay_cur_q) begin
                    fill_cnt_d = fill_next[ADDR_W-1:0];
                end
                // The sample completing the fill is still muted; the next
                // one is the first with genuine history behind it.
                if (fill_next == {1'b0, delay_cur_q}) begin
                    state_d = RUN;
                end
            end
        end

        // A new delay invalidates history: restart the fill. The write
        // pointer and RAM contents are left alone.
        if (delay_load) begin
            delay_cur_d = (delay_req == '0) ? {{(ADDR_W-1){1'b0}}, 1'b1}
                                            : delay_req;
            fill_cnt_d  = '0;
            state_d     = FILL;
        end

        busy_d = (state_d == FILL);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= FILL;
            wptr_q      <= '0;
            fill_cnt_q  <= '0;
            delay_cur_q <= {{(ADDR_W-1){1'b0}}, 1'b1};
            ram_waddr_q <= '0;
            ram_raddr_q <= '0;
            ram_we_q    <= 1'b0;
            issue_en_q  <= 1'b0;
            busy_q      <= 1'b0;
            alpha_q     <= '0;
        end else begin
            state_q     <= state_d;
            wptr_q      <= wptr_d;
            fill_cnt_q  <= fill_cnt_d;
            delay_cur_q <= delay_cur_d;
            ram_waddr_q <= ram_waddr_d;
            ram_raddr_q <= ram_raddr_d;
            ram_we_q    <= ram_we_d;
            issue_en_q  <= issue_en_d;
            busy_q      <= busy_d;
            alpha_q     <= alpha_d;
        end
    end

    echo_valid_pipe #(
        .DEPTH (RD_LAT)
    ) u_valid_pipe (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (ram_we_q),
        .in_en     (issue_en_q),
        .out_valid (echo_valid),
        .out_en    (echo_en)
    );

    assign ram_we    = ram_we_q;
    assign ram_waddr = ram_waddr_q;
    assign ram_raddr = ram_raddr_q;
    assign alpha_out = alpha_q;
    assign delay_cur = delay_cur_q;
    assign busy      = busy_q;

endmodule

`default_nettype wire

// File: tb/tb_echo_delay_ctrl.sv
// ============================================================================
// Module  : tb_echo_delay_ctrl
// Purpose : Directed self-checking bench for echo_delay_ctrl with ADDR_W=4,
//           RD_LAT=2, ALPHA_STEP=64. Alpha expectations follow
//           ECHO_ALPHA_RAMP_EN when it is defined for the build.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_echo_delay_ctrl;

    localparam int AW = 4;
    localparam int RD = 2;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 sample_valid;
    logic [AW-1:0]        delay_req;
    logic                 delay_load;
    logic signed [15:0]   alpha_req;
    logic                 ram_we;
    logic [AW-1:0]        ram_waddr;
    logic [AW-1:0]        ram_raddr;
    logic                 echo_valid;
    logic                 echo_en;
    logic signed [15:0]   alpha_out;
    logic [AW-1:0]        delay_cur;
    logic                 busy;

    int n_err = 0;
    int n_chk = 0;
    int ns    = 0;   // samples issued since last reset (alpha ramp position)

    always #5 clk = ~clk;

    echo_delay_ctrl #(
        .ADDR_W     (AW),
        .RD_LAT     (RD),
        .ALPHA_STEP (16'sd64)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .sample_valid (sample_valid),
        .delay_req    (delay_req),
        .delay_load   (delay_load),
        .alpha_req    (alpha_req),
        .ram_we       (ram_we),
        .ram_waddr    (ram_waddr),
        .ram_raddr    (ram_raddr),
        .echo_valid   (echo_valid),
        .echo_en      (echo_en),
        .alpha_out    (alpha_out),
        .delay_cur    (delay_cur),
        .busy         (busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Expected alpha_out after the n-th sample since reset, alpha_req = 200.
    function automatic logic [15:0] alpha_exp(input int n);
`ifdef ECHO_ALPHA_RAMP_EN
        if (n == 1)      return 16'd64;
        else if (n == 2) return 16'd128;
        else if (n == 3) return 16'd192;
        else             return 16'd200;
`else
        return (n >= 1) ? 16'd200 : 16'd0;
`endif
    endfunction

    // Issue one sample (optionally with a coincident delay_load) and follow
    // its flags through the RD=2 read pipeline.
    task automatic do_sample(input string tag, input int wa, input int ra,
                             input logic en, input logic load, input int dreq);
        sample_valid = 1'b1;
        delay_load   = load;
        delay_req    = AW'(dreq);
        step();
        sample_valid = 1'b0;
        delay_load   = 1'b0;
        ns++;
        chk({tag, ".we"},    32'(ram_we),    32'd1);
        chk({tag, ".waddr"}, 32'(ram_waddr), 32'(wa));
        chk({tag, ".raddr"}, 32'(ram_raddr), 32'(ra));
        chk({tag, ".alpha"}, {16'h0, alpha_out}, {16'h0, alpha_exp(ns)});
        step();
        chk({tag, ".we_off"}, 32'(ram_we),     32'd0);
        chk({tag, ".ev_early"}, 32'(echo_valid), 32'd0);
        step();
        chk({tag, ".ev"}, 32'(echo_valid), 32'd1);
        chk({tag, ".en"}, 32'(echo_en),    32'(en));
        step();
        chk({tag, ".ev_off"}, 32'(echo_valid), 32'd0);
    endtask

    task automatic do_load(input int d);
        delay_req  = AW'(d);
        delay_load = 1'b1;
        step();
        delay_load = 1'b0;
    endtask

    initial begin
        rst          = 1'b1;
        sample_valid = 1'b0;
        delay_req    = '0;
        delay_load   = 1'b0;
        alpha_req    = 16'sd0;
        step();
        step();

        // Reset state
        chk("rst.we",    32'(ram_we),     32'd0);
        chk("rst.ev",    32'(echo_valid), 32'd0);
        chk("rst.en",    32'(echo_en),    32'd0);
        chk("rst.busy",  32'(busy),       32'd0);
        chk("rst.waddr", 32'(ram_waddr),  32'd0);
        chk("rst.raddr", 32'(ram_raddr),  32'd0);
        chk("rst.delay", 32'(delay_cur),  32'd1);
        chk("rst.alpha", {16'h0, alpha_out}, 32'd0);

        rst = 1'b0;
        step();
        chk("fill.busy", 32'(busy), 32'd1);

        // Delay 3: first three samples muted, then history
        do_load(3);
        chk("load3.delay", 32'(delay_cur), 32'd3);
        chk("load3.busy",  32'(busy),      32'd1);
        alpha_req = 16'sd200;
        do_sample("s1", 0, 13, 1'b0, 1'b0, 0);
        do_sample("s2", 1, 14, 1'b0, 1'b0, 0);
        chk("s2.busy", 32'(busy), 32'd1);
        do_sample("s3", 2, 15, 1'b0, 1'b0, 0);
        chk("s3.busy", 32'(busy), 32'd0);

        // Steady RUN through pointer wrap (waddr 15 -> 0, raddr 13)
        for (int k = 3; k < 20; k++) begin
            do_sample("run", k % 16, (k + 13) % 16, 1'b1, 1'b0, 0);
        end

        // delay_load=5 coincident with a sample: old delay and old echo_en
        do_sample("cload", 4, 1, 1'b1, 1'b1, 5);
        chk("cload.delay", 32'(delay_cur), 32'd5);
        chk("cload.busy",  32'(busy),      32'd1);
        for (int k = 5; k < 10; k++) begin
            do_sample("fill5", k, (k + 11) % 16, 1'b0, 1'b0, 0);
        end
        do_sample("run5", 10, 5, 1'b1, 1'b0, 0);
        chk("run5.busy", 32'(busy), 32'd0);

        // delay_load=0 clamps to 1
        do_load(0);
        chk("load0.delay", 32'(delay_cur), 32'd1);
        chk("load0.busy",  32'(busy),      32'd1);
        do_sample("d1a", 11, 10, 1'b0, 1'b0, 0);
        chk("d1a.busy", 32'(busy), 32'd0);
        do_sample("d1b", 12, 11, 1'b1, 1'b0, 0);

        // Reload while still filling restarts the fill
        do_load(4);
        do_sample("f4", 13, 9, 1'b0, 1'b0, 0);
        do_load(2);
        chk("load2.delay", 32'(delay_cur), 32'd2);
        do_sample("f2a", 14, 12, 1'b0, 1'b0, 0);
        do_sample("f2b", 15, 13, 1'b0, 1'b0, 0);
        do_sample("r2",  0,  14, 1'b1, 1'b0, 0);

        // Back-to-back samples
        sample_valid = 1'b1;
        step();
        chk("b2b1.we",    32'(ram_we),    32'd1);
        chk("b2b1.waddr", 32'(ram_waddr), 32'd1);
        chk("b2b1.raddr", 32'(ram_raddr), 32'd15);
        step();
        sample_valid = 1'b0;
        ns += 2;
        chk("b2b2.we",    32'(ram_we),    32'd1);
        chk("b2b2.waddr", 32'(ram_waddr), 32'd2);
        chk("b2b2.raddr", 32'(ram_raddr), 32'd0);
        step();
        chk("b2b3.we", 32'(ram_we),     32'd0);
        chk("b2b3.ev", 32'(echo_valid), 32'd1);
        chk("b2b3.en", 32'(echo_en),    32'd1);
        step();
        chk("b2b4.ev", 32'(echo_valid), 32'd1);
        chk("b2b4.en", 32'(echo_en),    32'd1);
        step();
        chk("b2b5.ev", 32'(echo_valid), 32'd0);

        // Reset mid-RUN with a sample in flight
        sample_valid = 1'b1;
        step();
        sample_valid = 1'b0;
        chk("inflight.we",    32'(ram_we),    32'd1);
        chk("inflight.waddr", 32'(ram_waddr), 32'd3);
        rst = 1'b1;
        step();
        chk("mrst.we",    32'(ram_we),     32'd0);
        chk("mrst.waddr", 32'(ram_waddr),  32'd0);
        chk("mrst.raddr", 32'(ram_raddr),  32'd0);
        chk("mrst.ev",    32'(echo_valid), 32'd0);
        chk("mrst.en",    32'(echo_en),    32'd0);
        chk("mrst.busy",  32'(busy),       32'd0);
        chk("mrst.delay", 32'(delay_cur),  32'd1);
        chk("mrst.alpha", {16'h0, alpha_out}, 32'd0);
        rst = 1'b0;
        ns  = 0;
        for (int k = 0; k < 3; k++) begin
            step();
            chk("mrst.no_ev", 32'(echo_valid), 32'd0);
        end
        do_sample("post", 0, 15, 1'b0, 1'b0, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/echo_delay_ctrl.md
Name: echo_delay_ctrl

Overview:
- Sequencer for the echo delay line. It owns the BRAM write/read pointers, sample-rate write strobes, the echo-enable gate and the alpha (echo gain) register.
- Sits between the audio sample stream (LPF2 output, one sample_valid strobe per sample) and the echo datapath: delay RAM, gain multiply, round and sum junction.
- Handles run-time delay changes by muting the echo and refilling the delay line, so no stale-history click is heard.

Parameters:
- ADDR_W, 20, delay-RAM address width; depth = 2**ADDR_W samples; pointers wrap naturally.
- RD_LAT, 1, BRAM read latency in clk cycles (1..4).
- ALPHA_STEP, 16'd64, per-sample alpha increment/decrement magnitude (used only with ramp feature).

Ports:
- clk, in, 1: system clock.
- rst, in, 1: synchronous, active-high reset.
- sample_valid, in, 1: one-cycle strobe, a new input sample is present.
- delay_req, in, ADDR_W: requested delay in samples.
- delay_load, in, 1: one-cycle strobe, latch delay_req.
- alpha_req, in, 16 signed: requested echo gain, Q1.15.
- ram_we, out, 1: BRAM write enable (one cycle per sample).
- ram_waddr, out, ADDR_W: BRAM write address.
- ram_raddr, out, ADDR_W: BRAM read address.
- echo_valid, out, 1: BRAM read data for the current sample is valid (ram_we delayed RD_LAT).
- echo_en, out, 1: delayed data is real history; datapath gates ram_out with it.
- alpha_out, out, 16 signed: gain presented to the multiplier.
- delay_cur, out, ADDR_W: delay currently in effect.
- busy, out, 1: high in FILL state (echo muted).

Behaviour:
- Reset values:
  - ram_we, echo_valid, echo_en, busy = 0.
  - ram_waddr, ram_raddr = 0; wptr = 0; fill_cnt = 0.
  - delay_cur = 1; alpha_out = 0.
  - State = FILL.
  - rst asserted mid-operation aborts everything the same way; in-flight echo_valid pipeline is cleared.
- Delay clamp on load: 0 becomes 1; values above 2**ADDR_W-1 are impossible by width.
- Sample issue: the cycle after sample_valid=1:
  - ram_we=1, ram_waddr=wptr.
  - ram_raddr = wptr - delay_cur, modulo 2**ADDR_W.
  - wptr then increments and wraps from all-ones to 0.
  - ram_we is high exactly one cycle per sample. Back-to-back sample_valid on consecutive cycles is legal and gives back-to-back writes.
- echo_valid = ram_we delayed RD_LAT cycles. echo_en is registered alongside it in the same pipeline.
- echo_en for a sample = 1 iff the FSM was in RUN when that sample was issued. Otherwise echo_en = 0 and the datapath passes only the dry signal.
- fill_cnt increments on each issued sample in FILL and saturates at delay_cur.
- FSM states:
  - FILL: busy=1.
    - Goes to RUN on the issue cycle where fill_cnt+1 == delay_cur.
    - That sample is still muted; the next sample has echo_en=1.
  - RUN: busy=0; stays in RUN until delay_load.
  - delay_load in any state:
    - delay_cur <= clamp(delay_req); fill_cnt <= 0; state <= FILL.
    - wptr is kept and RAM contents are not cleared.
- Simultaneous sample_valid and delay_load: the sample is issued with the OLD delay_cur and the old echo_en. The new delay applies from the next sample, and fill counting restarts at 0 (the coincident sample does not count).
- delay_load repeated while in FILL restarts the fill with the new value.
- Alpha:
  - alpha_out updates only on sample issue cycles, so gain never changes mid-sample.
  - Without the ramp feature: alpha_out <= alpha_req at each issue.

Optional Feature:
- Macro: ECHO_ALPHA_RAMP_EN.
- Defined: at each issue, alpha_out moves toward alpha_req by ALPHA_STEP. It snaps to alpha_req when |alpha_req - alpha_out| <= ALPHA_STEP. The difference is computed in 17 bits to avoid overflow.
- Not defined: alpha_out loads alpha_req directly at each issue; no ramp logic is synthesised.

Decomposition:
- Package echo_pkg:
  - typedef enum logic [0:0] {FILL, RUN} echo_state_t.
  - localparam ALPHA_W = 16.
  - typedef logic signed [ALPHA_W-1:0] alpha_t.
  - Default ALPHA_STEP constant.
- One sub-module: echo_valid_pipe, an RD_LAT-deep shift register carrying {echo_valid, echo_en}, cleared by rst.

Test Plan:
- Reset then delay_load=3 with ADDR_W=4; 6 samples -> waddr 0..5, raddr 13,14,15,0,1,2; echo_en 0,0,0,1,1,1 (each RD_LAT after ram_we); busy low after 3rd sample.
- Wrap: 20 samples, delay 3, ADDR_W=4 -> waddr goes 15->0; sample 16 has raddr 13; echo_en stays 1.
- In RUN, delay_load=5 coincident with sample_valid -> that sample uses delay 3 with echo_en=1; next 5 samples have echo_en=0 and raddr=waddr-5; 6th sample has echo_en=1.
- delay_load=0 -> delay_cur=1; second sample has echo_en=1, raddr=waddr-1.
- rst asserted mid-RUN with echo_valid in flight -> next cycle all outputs are at reset values, no echo_valid pulse emerges, next sample writes address 0.
- Ramp (ECHO_ALPHA_RAMP_EN, ALPHA_STEP=64): alpha_req 0->200 -> alpha_out 64,128,192,200 on successive samples; without the macro, alpha_out=200 at the first sample.
